// File: rtl/riscv_dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// The state encodings double as the "last owner" record used for round-robin.
package riscv_dmem_arbiter_pkg;
    localparam int ARB_XLEN = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;
endpackage

// File: rtl/riscv_dmem_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and riscv_dmem.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface riscv_dmem_arbiter_if
    import riscv_dmem_arbiter_pkg::*;
#(
    parameter int XLEN = ARB_XLEN
);
    logic            i_m0_req;
    logic            i_m0_wr_en;
    logic [3:0]      i_m0_byte_sel;
    logic [XLEN-1:0] i_m0_addr;
    logic [XLEN-1:0] i_m0_wr_data;
    logic            o_m0_gnt;
    logic [XLEN-1:0] o_m0_rd_data;
    logic            o_m0_rd_valid;

    logic            i_m1_req;
    logic            i_m1_wr_en;
    logic [3:0]      i_m1_byte_sel;
    logic [XLEN-1:0] i_m1_addr;
    logic [XLEN-1:0] i_m1_wr_data;
    logic            i_m1_lock;
    logic            o_m1_gnt;
    logic [XLEN-1:0] o_m1_rd_data;
    logic            o_m1_rd_valid;

    logic [XLEN-1:0] o_dmem_addr;
    logic            o_dmem_wr_en;
    logic [3:0]      o_dmem_byte_sel;
    logic [XLEN-1:0] o_dmem_wr_data;
    logic [XLEN-1:0] i_dmem_rd_data;

    modport slave (
        input  i_m0_req, i_m0_wr_en, i_m0_byte_sel, i_m0_addr, i_m0_wr_data,
        output o_m0_gnt, o_m0_rd_data, o_m0_rd_valid,
        input  i_m1_req, i_m1_wr_en, i_m1_byte_sel, i_m1_addr, i_m1_wr_data, i_m1_lock,
        output o_m1_gnt, o_m1_rd_data, o_m1_rd_valid,
        output o_dmem_addr, o_dmem_wr_en, o_dmem_byte_sel, o_dmem_wr_data,
        input  i_dmem_rd_data
    );

    modport master (
        output i_m0_req, i_m0_wr_en, i_m0_byte_sel, i_m0_addr, i_m0_wr_data,
        input  o_m0_gnt, o_m0_rd_data, o_m0_rd_valid,
        output i_m1_req, i_m1_wr_en, i_m1_byte_sel, i_m1_addr, i_m1_wr_data, i_m1_lock,
        input  o_m1_gnt, o_m1_rd_data, o_m1_rd_valid,
        input  o_dmem_addr, o_dmem_wr_en, o_dmem_byte_sel, o_dmem_wr_data,
        output i_dmem_rd_data
    );
endinterface

// File: rtl/riscv_dmem_arbiter_rdret.sv
// Per-master read-return register: captures load data on acceptance and
// raises a one-cycle valid the cycle after.
module riscv_dmem_arbiter_rdret #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_data,
    output logic            o_valid
);
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_load;
            if (i_load) begin
                o_data <= i_data;
            end
        end
    end
endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Round-robin arbiter sharing riscv_dmem between the core (master 0) and the
// debug/loader port (master 1), with a bounded burst lock for master 1.
module riscv_dmem_arbiter
    import riscv_dmem_arbiter_pkg::*;
#(
    parameter int XLEN     = ARB_XLEN,
    parameter int MAX_LOCK = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    riscv_dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             gnt0, gnt1;
    logic             load0, load1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= ARB_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Grants are gated by reset so nothing reaches memory while it is held.
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        state_nxt    = ARB_IDLE;
        hold_cnt_nxt = '0;
        if (i_rstn) begin
            if (bus.i_m0_req && !bus.i_m1_req) begin
                gnt0 = 1'b1;
            end else if (bus.i_m1_req && !bus.i_m0_req) begin
                gnt1 = 1'b1;
            end else if (bus.i_m0_req && bus.i_m1_req) begin
                unique case (state)
                    ARB_OWN0: gnt1 = 1'b1;
                    ARB_OWN1: begin
                        if (bus.i_m1_lock && (hold_cnt < CNT_W'(MAX_LOCK))) gnt1 = 1'b1;
                        else                                                gnt0 = 1'b1;
                    end
                    default:  gnt0 = 1'b1;
                endcase
            end
        end
        if (gnt0) begin
            state_nxt = ARB_OWN0;
        end else if (gnt1) begin
            state_nxt = ARB_OWN1;
            if (state != ARB_OWN1)                    hold_cnt_nxt = CNT_W'(1);
            else if (hold_cnt == CNT_W'(MAX_LOCK))    hold_cnt_nxt = hold_cnt;
            else                                      hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        bus.o_dmem_addr     = '0;
        bus.o_dmem_wr_en    = 1'b0;
        bus.o_dmem_byte_sel = '0;
        bus.o_dmem_wr_data  = '0;
        if (gnt0) begin
            bus.o_dmem_addr     = bus.i_m0_addr;
            bus.o_dmem_wr_en    = bus.i_m0_wr_en;
            bus.o_dmem_byte_sel = bus.i_m0_byte_sel;
            bus.o_dmem_wr_data  = bus.i_m0_wr_data;
        end else if (gnt1) begin
            bus.o_dmem_addr     = bus.i_m1_addr;
            bus.o_dmem_wr_en    = bus.i_m1_wr_en;
            bus.o_dmem_byte_sel = bus.i_m1_byte_sel;
            bus.o_dmem_wr_data  = bus.i_m1_wr_data;
        end
    end

    assign bus.o_m0_gnt = gnt0;
    assign bus.o_m1_gnt = gnt1;
    assign load0 = bus.i_m0_req && gnt0 && !bus.i_m0_wr_en;
    assign load1 = bus.i_m1_req && gnt1 && !bus.i_m1_wr_en;

    riscv_dmem_arbiter_rdret #(.XLEN(XLEN)) u_rdret0 (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_load  (load0),
        .i_data  (bus.i_dmem_rd_data),
        .o_data  (bus.o_m0_rd_data),
        .o_valid (bus.o_m0_rd_valid)
    );

    riscv_dmem_arbiter_rdret #(.XLEN(XLEN)) u_rdret1 (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_load  (load1),
        .i_data  (bus.i_dmem_rd_data),
        .o_data  (bus.o_m1_rd_data),
        .o_valid (bus.o_m1_rd_valid)
    );
endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Directed bench for riscv_dmem_arbiter with a small word memory standing in for riscv_dmem.
module tb_riscv_dmem_arbiter;
    import riscv_dmem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;
    int   idx;
    logic exp1;

    riscv_dmem_arbiter_if #(.XLEN(32)) bus ();

    riscv_dmem_arbiter #(.XLEN(32), .MAX_LOCK(4)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:15];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (bus.o_dmem_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.o_dmem_byte_sel[b])
                    mem[bus.o_dmem_addr[5:2]][b*8 +: 8] <= bus.o_dmem_wr_data[b*8 +: 8];
        end
    end

    assign bus.i_dmem_rd_data = mem[bus.o_dmem_addr[5:2]];

    function automatic logic [31:0] bdata(input int i);
        return 32'hB000_0000 | (32'(i) * 32'h11);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data);
        bus.i_m0_req      = req;
        bus.i_m0_wr_en    = we;
        bus.i_m0_byte_sel = 4'hF;
        bus.i_m0_addr     = addr;
        bus.i_m0_wr_data  = data;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic lock);
        bus.i_m1_req      = req;
        bus.i_m1_wr_en    = we;
        bus.i_m1_byte_sel = 4'hF;
        bus.i_m1_addr     = addr;
        bus.i_m1_wr_data  = data;
        bus.i_m1_lock     = lock;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both masters requesting
        rstn = 1'b0;
        set_m0(1'b1, 1'b0, 32'h0, 32'h0);
        set_m1(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk); #1;
        chk("rst_gnt0", 32'(bus.o_m0_gnt), 32'd0);
        chk("rst_gnt1", 32'(bus.o_m1_gnt), 32'd0);
        chk("rst_vld0", 32'(bus.o_m0_rd_valid), 32'd0);
        chk("rst_vld1", 32'(bus.o_m1_rd_valid), 32'd0);
        chk("rst_wr_en", 32'(bus.o_dmem_wr_en), 32'd0);
        chk("rst_rdata0", bus.o_m0_rd_data, 32'd0);

        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rel_gnt0", 32'(bus.o_m0_gnt), 32'd1);
        chk("rel_gnt1", 32'(bus.o_m1_gnt), 32'd0);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;

        // Lone store then lone load at 0x10
        @(negedge clk);
        set_m0(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        #1;
        chk("st_gnt0", 32'(bus.o_m0_gnt), 32'd1);
        chk("st_wr_en", 32'(bus.o_dmem_wr_en), 32'd1);
        chk("st_addr", bus.o_dmem_addr, 32'h10);
        @(posedge clk); #1;
        chk("st_novld", 32'(bus.o_m0_rd_valid), 32'd0);
        chk("st_mem", mem[4], 32'hDEADBEEF);

        @(negedge clk);
        set_m0(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        chk("ld_gnt0", 32'(bus.o_m0_gnt), 32'd1);
        chk("ld_wr_en", 32'(bus.o_dmem_wr_en), 32'd0);
        @(posedge clk); #1;
        chk("ld_vld0", 32'(bus.o_m0_rd_valid), 32'd1);
        chk("ld_rdata0", bus.o_m0_rd_data, 32'hDEADBEEF);
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("ld_vld0_pulse", 32'(bus.o_m0_rd_valid), 32'd0);
        chk("ld_rdata0_hold", bus.o_m0_rd_data, 32'hDEADBEEF);

        // Contention without lock: strict alternation starting with m0
        @(negedge clk);
        set_m0(1'b1, 1'b0, 32'h10, 32'h0);
        set_m1(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk($sformatf("alt_gnt0_%0d", i), 32'(bus.o_m0_gnt), 32'((i % 2) == 0));
            chk($sformatf("alt_gnt1_%0d", i), 32'(bus.o_m1_gnt), 32'((i % 2) == 1));
            @(posedge clk); #1;
            if ((i % 2) == 1) begin
                chk($sformatf("alt_vld1_%0d", i), 32'(bus.o_m1_rd_valid), 32'd1);
                chk($sformatf("alt_rd1_%0d", i), bus.o_m1_rd_data, 32'hDEADBEEF);
            end else begin
                chk($sformatf("alt_vld0_%0d", i), 32'(bus.o_m0_rd_valid), 32'd1);
            end
        end
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("alt_idle", 32'(dut.state), 32'(ARB_IDLE));

        // Locked burst from OWN0: m1 x4, m0, m1 x4
        @(negedge clk);
        set_m0(1'b1, 1'b0, 32'h3C, 32'h0);
        @(posedge clk); #1;
        chk("burst_own0", 32'(dut.state), 32'(ARB_OWN0));
        idx = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            set_m1(1'b1, 1'b1, 32'(idx * 4), bdata(idx), 1'b1);
            #1;
            exp1 = (c != 4);
            chk($sformatf("burst_gnt1_%0d", c), 32'(bus.o_m1_gnt), 32'(exp1));
            chk($sformatf("burst_gnt0_%0d", c), 32'(bus.o_m0_gnt), 32'(!exp1));
            @(posedge clk); #1;
            if (bus.o_m1_gnt === 1'b0 && exp1) idx++;
            else if (exp1) idx++;
            if (c == 3) chk("burst_hold_sat", 32'(dut.hold_cnt), 32'd4);
            if (c == 4) chk("burst_hold_clr", 32'(dut.hold_cnt), 32'd0);
        end
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++)
            chk($sformatf("burst_mem_%0d", i), mem[i], bdata(i));

        // Lock drop after two locked grants
        @(negedge clk);
        set_m0(1'b1, 1'b0, 32'h3C, 32'h0);
        set_m1(1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b1);
        #1;
        chk("drop_first_m0", 32'(bus.o_m0_gnt), 32'd1);
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            chk($sformatf("drop_gnt1_%0d", c), 32'(bus.o_m1_gnt), 32'd1);
            @(posedge clk); #1;
        end
        chk("drop_hold2", 32'(dut.hold_cnt), 32'd2);
        @(negedge clk);
        bus.i_m1_lock = 1'b0;
        #1;
        chk("drop_gnt0", 32'(bus.o_m0_gnt), 32'd1);
        chk("drop_gnt1_low", 32'(bus.o_m1_gnt), 32'd0);
        @(posedge clk); #1;
        chk("drop_hold0", 32'(dut.hold_cnt), 32'd0);
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;

        // Reset right after an accepted m1 load
        @(negedge clk);
        set_m1(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("mid_vld1", 32'(bus.o_m1_rd_valid), 32'd1);
        chk("mid_rd1", bus.o_m1_rd_data, bdata(1));
        rstn = 1'b0;
        #1;
        chk("mid_vld1_cut", 32'(bus.o_m1_rd_valid), 32'd0);
        chk("mid_rd1_clr", bus.o_m1_rd_data, 32'd0);
        chk("mid_gnt1_rst", 32'(bus.o_m1_gnt), 32'd0);
        chk("mid_state", 32'(dut.state), 32'(ARB_IDLE));
        @(negedge clk);
        rstn = 1'b1;
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("mid_no_stale1", 32'(bus.o_m1_rd_valid), 32'd0);
        @(posedge clk); #1;
        chk("mid_no_stale2", 32'(bus.o_m1_rd_valid), 32'd0);
        chk("mid_idle", 32'(dut.state), 32'(ARB_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
